// File: rtl/net_loader_pkg.sv
// net_loader_pkg: shared types and constants for the net_proc image loader.
// Sequencer states, default image size and result encoding used by
// net_image_loader.
package net_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        START,
        WAIT,
        RESULT
    } loader_state_e;

    localparam int N_IMG_BYTES = 784;
    localparam int RES_W = 4;
    localparam logic [RES_W-1:0] RES_TIMEOUT_CODE = 4'hF;

endpackage

// File: rtl/net_image_loader.sv
// net_image_loader: drives net_proc's external image port from a byte stream.
// Clears the image memory, writes N_BYTES pixels in order, pulses start,
// waits for done and returns the class index on a valid/ready handshake.
// Optional build macro NET_LOADER_TIMEOUT_EN adds a WAIT-state watchdog that
// reports RES_TIMEOUT_CODE with res_err=1 when net_proc never completes.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no image in flight; first s_valid starts a new image
// CLEAR  | ext_mem_rst pulse, byte counter cleared
// LOAD   | accept bytes, one registered write strobe per handshake
// START  | last write strobe on the port, start pulse being registered
// WAIT   | start visible; waiting for a rising edge on done
// RESULT | result presented, held until res_ready
module net_image_loader
    import net_loader_pkg::*;
#(
    parameter int N_BYTES        = N_IMG_BYTES,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             ext_mem_rst,
    output logic             ext_mem_we,
    output logic [7:0]       ext_mem_wdata,
    output logic             start,
    input  logic             done,
    input  logic [RES_W-1:0] max_idx_10,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] result,
    output logic             res_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_BYTES);

    loader_state_e    state;
    logic [CNT_W-1:0] byte_cnt;
    logic             done_q;
    logic             done_rise;
    logic             accept;

    // s_ready falls as soon as the counter is full so no extra byte slips in
    assign s_ready   = (state == LOAD) && (byte_cnt != FULL_CNT);
    assign accept    = s_valid && s_ready;
    assign done_rise = done && !done_q;
    assign busy      = (state != IDLE);

`ifdef NET_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            res_err_q;

    assign wd_expired = (wd_cnt == '0);
    assign res_err    = res_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0) ^ (RES_TIMEOUT_CODE != '0);
    assign res_err        = 1'b0;
`endif

    // Sequencer: state, byte counter, done edge tracking and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            done_q        <= 1'b0;
            ext_mem_rst   <= 1'b0;
            ext_mem_we    <= 1'b0;
            ext_mem_wdata <= '0;
            start         <= 1'b0;
            res_valid     <= 1'b0;
            result        <= '0;
`ifdef NET_LOADER_TIMEOUT_EN
            wd_cnt        <= '0;
            res_err_q     <= 1'b0;
`endif
        end else begin
            // done_q runs in every state so a level left high from an earlier
            // run (or arriving after a timeout) never looks like a new edge
            done_q      <= done;
            ext_mem_rst <= 1'b0;
            ext_mem_we  <= 1'b0;
            start       <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        ext_mem_rst <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    byte_cnt <= '0;
                    state    <= LOAD;
                end
                LOAD: begin
                    if (accept) begin
                        ext_mem_we    <= 1'b1;
                        ext_mem_wdata <= s_data;
                        byte_cnt      <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_IDX) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    start <= 1'b1;
                    state <= WAIT;
`ifdef NET_LOADER_TIMEOUT_EN
                    wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
                end
                WAIT: begin
                    if (done_rise) begin
                        result    <= max_idx_10;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
`ifdef NET_LOADER_TIMEOUT_EN
                    else if (wd_expired) begin
                        result    <= RES_TIMEOUT_CODE;
                        res_err_q <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
`endif
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
`ifdef NET_LOADER_TIMEOUT_EN
                        res_err_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_net_image_loader.sv
// tb_net_image_loader: scoreboard bench for net_image_loader with a stub net_proc.
// Handshaken bytes are queued as expected writes; stub completions are queued
// as expected results. Honours NET_LOADER_TIMEOUT_EN for the watchdog case.
module tb_net_image_loader;

    localparam int N = 784;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       ext_mem_rst;
    logic       ext_mem_we;
    logic [7:0] ext_mem_wdata;
    logic       start;
    logic       done;
    logic [3:0] max_idx_10;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] result;
    logic       res_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [4:0] res_q[$];

    int cyc         = 0;
    int we_cnt      = 0;
    int acc_cnt     = 0;
    int last_we_cyc = 0;
    int rst_pulses  = 0;
    bit prev_rst    = 0;
    bit prev_start  = 0;
    bit abort       = 0;

    net_image_loader #(
        .N_BYTES        (N),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .ext_mem_rst   (ext_mem_rst),
        .ext_mem_we    (ext_mem_we),
        .ext_mem_wdata (ext_mem_wdata),
        .start         (start),
        .done          (done),
        .max_idx_10    (max_idx_10),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .result        (result),
        .res_err       (res_err),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Port monitor: write scoreboard, clear/start pulse shape and counts
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (ext_mem_we) begin
                if (exp_q.size() == 0) begin
                    check("we_unexpected", 32'(ext_mem_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wdata", 32'(ext_mem_wdata), 32'(e));
                end
                we_cnt++;
                last_we_cyc = cyc;
            end
            if (ext_mem_rst) begin
                check("clr_width", 32'(prev_rst), 32'd0);
                check("q_empty_at_clr", exp_q.size(), 32'd0);
                rst_pulses++;
                we_cnt  = 0;
                acc_cnt = 0;
            end
            if (start) begin
                check("start_gap", cyc - last_we_cyc, 32'd1);
                check("we_count", we_cnt, N);
                check("start_width", 32'(prev_start), 32'd0);
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                acc_cnt++;
                check("acc_le_n", 32'(acc_cnt <= N), 32'd1);
            end
            prev_rst   = ext_mem_rst;
            prev_start = start;
        end
    end

    task automatic send_image(input int n, input int gap_pct, input logic [7:0] base);
        bit hs;
        int budget;
        for (int i = 0; i < n; i++) begin
            if (abort) break;
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = base + 8'(i);
            hs      = 1'b0;
            budget  = 0;
            while (!hs && !abort && budget < 2000) begin
                @(negedge clk);
                hs = s_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!hs && !abort) begin
                check("send_stall", 32'(hs), 32'd1);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    // Stub net_proc: keeps done as-is for 'hold' cycles, drops it, raises after 'lat'
    task automatic stub(input int hold, input int lat, input int idx);
        bit got;
        got = 1'b0;
        for (int b = 0; b < 30000; b++) begin
            @(negedge clk);
            if (start) begin
                got = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(got), 32'd1);
        if (!got) return;
        repeat (hold) @(negedge clk);
        if (hold > 0) check("no_false_done", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        done       = 1'b0;
        max_idx_10 = ~4'(idx);
        repeat (lat) @(posedge clk);
        #1;
        max_idx_10 = 4'(idx);
        done       = 1'b1;
        res_q.push_back({1'b0, 4'(idx)});
        repeat (3) @(posedge clk);
        #1;
        max_idx_10 = ~4'(idx);
    endtask

    task automatic take_result(input int hold, input bit chk_clear);
        logic [4:0] e;
        bit got;
        bit seen;
        got = 1'b0;
        for (int b = 0; b < 20000; b++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("res_valid_seen", 32'(got), 32'd1);
        if (!got) return;
        if (res_q.size() == 0) begin
            check("res_q_nonempty", 32'd0, 32'd1);
            return;
        end
        e = res_q.pop_front();
        for (int k = 0; k < hold; k++) begin
            check("res_valid_hold", 32'(res_valid), 32'd1);
            check("result_hold", 32'(result), 32'(e[3:0]));
            check("res_err_hold", 32'(res_err), 32'(e[4]));
            check("s_ready_stall", 32'(s_ready), 32'd0);
            @(negedge clk);
        end
        check("result", 32'(result), 32'(e[3:0]));
        check("res_err", 32'(res_err), 32'(e[4]));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("res_err_clear", 32'(res_err), 32'd0);
        if (chk_clear) begin
            seen = ext_mem_rst;
            if (!seen) begin
                @(negedge clk);
                seen = ext_mem_rst;
            end
            check("clear_after_res", 32'(seen), 32'd1);
        end
    endtask

    initial begin
        bit got;
        int k;
        rst_n      = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        done       = 1'b0;
        max_idx_10 = '0;
        res_ready  = 1'b0;
        k          = 0;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_outs", 32'({s_ready, ext_mem_rst, ext_mem_we, ext_mem_wdata, start,
                               res_valid, result, res_err, busy}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_s_ready", 32'(s_ready), 32'd0);

        // single image, continuous stream, done after 50 cycles
        fork
            send_image(N, 0, 8'h00);
            stub(0, 50, 7);
        join
        take_result(5, 1'b0);
        check("clr_pulses_one", rst_pulses, 32'd1);

        // random gaps, then a 785th byte that must not be taken
        fork
            send_image(N, 30, 8'h55);
            stub(0, 20, 5);
        join
        s_valid = 1'b1;
        s_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("byte_785_refused", 32'(s_ready), 32'd0);
        end

        // result held 20 cycles with the next image already waiting;
        // that image sees done stuck high from the previous run
        fork
            take_result(20, 1'b1);
            send_image(N, 0, 8'hC3);
            stub(30, 10, 3);
        join
        take_result(2, 1'b0);

        // asynchronous reset after byte 400
        acc_cnt = 0;
        fork
            send_image(N, 0, 8'h10);
            begin
                got = 1'b0;
                for (int b = 0; b < 5000; b++) begin
                    @(negedge clk);
                    if (acc_cnt >= 400) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("reach_400", 32'(got), 32'd1);
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_outs", 32'({s_ready, ext_mem_rst, ext_mem_we, ext_mem_wdata, start,
                                             res_valid, result, res_err, busy}), 32'd0);
                abort = 1'b1;
            end
        join
        s_valid = 1'b0;
        exp_q.delete();
        abort = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        fork
            send_image(N, 10, 8'h21);
            stub(0, 5, 9);
        join
        take_result(3, 1'b0);

        // net_proc never completes
        done = 1'b0;
        fork
            send_image(N, 0, 8'h3C);
            begin
                got = 1'b0;
                for (int b = 0; b < 5000; b++) begin
                    @(negedge clk);
                    if (start) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("hang_start_seen", 32'(got), 32'd1);
                for (k = 1; k <= 300; k++) begin
                    @(negedge clk);
                    if (res_valid) break;
                end
            end
        join
`ifdef NET_LOADER_TIMEOUT_EN
        check("timeout_wait_cycles", k, 32'd100);
        res_q.push_back(5'h1F);
        take_result(2, 1'b0);
`else
        check("no_timeout_valid", 32'(res_valid), 32'd0);
        check("no_timeout_err", 32'(res_err), 32'd0);
        check("still_waiting", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/net_image_loader.md
Name: net_image_loader

Overview:
- Initiator-side sequencer for `net_proc`'s external image memory port.
- Accepts a valid/ready byte stream (from a UART, DMA or host bridge), clears the image memory, and writes exactly N_BYTES pixels in order.
- Then pulses `start`, waits for `net_proc` to finish, and presents the 4-bit classification on a valid/ready result handshake.
- Sits between the host I/O front end and `net_proc`, replacing the bench-driven write/start sequence in hardware.

Parameters:
- N_BYTES, 784: pixels per image (28*28); must be >= 1.
- TIMEOUT_CYCLES, 1048576: WAIT-state watchdog limit; used only with the optional feature.
- CNT_W, $clog2(N_BYTES+1): localparam, byte counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input pixel byte.
- s_ready  out  1  loader can accept a byte.
- ext_mem_rst  out  1  to `net_proc`: clear/rewind image write pointer.
- ext_mem_we  out  1  to `net_proc`: write strobe.
- ext_mem_wdata  out  8  to `net_proc`: write data.
- start  out  1  to `net_proc`: one-cycle start pulse.
- done  in  1  from `net_proc`: inference complete (level).
- max_idx_10  in  4  from `net_proc`: winning class index.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- result  out  4  captured class index.
- res_err  out  1  result invalid (timeout); tied 0 without the optional feature.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: clk, async active-low rst_n. On rst_n low, all outputs are 0, the state is IDLE and the counter is 0.
  - Reset mid-operation aborts immediately; no further writes or start pulses are issued.
  - `net_proc` contents are undefined until the next CLEAR.
- All outputs to `net_proc` are registered; no combinational path from s_* or done to them.
- State machine: IDLE -> CLEAR -> LOAD -> START -> WAIT -> RESULT -> IDLE.
- IDLE:
  - s_ready=0.
  - On s_valid=1, go to CLEAR. The byte is not consumed.
- CLEAR:
  - ext_mem_rst=1 for exactly one cycle; counter cleared.
  - Next state LOAD.
- LOAD:
  - s_ready=1.
  - On each handshake (s_valid & s_ready), the next cycle shows ext_mem_we=1 and ext_mem_wdata=s_data, so write latency is 1 cycle.
  - Counter increments per handshake.
  - Gaps in s_valid produce ext_mem_we=0 cycles; no stuffing.
  - When the N_BYTES-th byte is accepted, s_ready drops in the same cycle it is registered (combinational from state/counter). No byte N_BYTES+1 is accepted.
  - Next state START.
- START:
  - Entered the cycle the last write strobe is on the port.
  - start=1 in the cycle after the last ext_mem_we, for exactly one cycle.
  - Next state WAIT.
- WAIT:
  - done is registered into done_q. Completion is done_rise = done & ~done_q, which tolerates `done` left high from the previous run.
  - On done_rise, capture max_idx_10 into result and go to RESULT.
  - s_ready=0.
- RESULT:
  - res_valid=1; result and res_err are held stable until res_ready.
  - On res_valid & res_ready, go to IDLE, deassert res_valid next cycle, and clear res_err.
  - Bytes arriving meanwhile are stalled (s_ready=0), never dropped.
- Back-to-back images: an immediately following s_valid causes CLEAR in the first IDLE cycle. Minimum image-to-image overhead is IDLE + CLEAR + START cycles plus `net_proc` latency.
- Counter wrap: never happens. It saturates at N_BYTES and is cleared only in CLEAR or reset.

Optional Feature:
- Macro: NET_LOADER_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without done_rise, go to RESULT with result=4'hF and res_err=1.
  - A late done after the timeout is ignored, because done_q is tracked continuously.
- Undefined:
  - No watchdog logic; WAIT waits indefinitely.
  - res_err is constant 0.

Decomposition:
- Package `net_loader_pkg`:
  - state enum `loader_state_e` (IDLE, CLEAR, LOAD, START, WAIT, RESULT).
  - N_IMG_BYTES=784, RES_W=4, RES_TIMEOUT_CODE=4'hF.
- No sub-module is natural: a single FSM plus counters. The watchdog stays inline under the macro guard.

Test Plan:
- Single image, continuous s_valid, 784 bytes 0x00..0xFF repeating:
  - One ext_mem_rst pulse, then 784 ext_mem_we strobes with matching data in order.
  - start exactly 1 cycle after the last strobe.
  - The stub net raises done 50 cycles later with max_idx_10=7; result=7 with res_valid until res_ready.
- Random s_valid gaps (≈30% idle):
  - Exactly 784 strobes; data order preserved; no write during gaps.
  - 785th byte offered is not accepted (s_ready=0).
- res_ready held low for 20 cycles with the next image already streaming:
  - res_valid and result stable for 20 cycles; s_ready=0 throughout.
  - After the handshake, a new CLEAR follows within 2 cycles.
- Stub holds done=1 continuously from the previous run:
  - No false completion; result is captured only after done falls and rises again (value 3).
- rst_n asserted asynchronously mid-LOAD (after byte 400):
  - All outputs 0 immediately; state IDLE.
  - A subsequent full image loads 784 bytes from a fresh CLEAR.
- With NET_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100, stub never asserts done:
  - res_valid after 100 WAIT cycles with result=4'hF and res_err=1.
  - Without the macro, res_valid stays 0 and res_err stays 0.
